// File: rtl/traffic_pkg.sv
// Shared types, lamp encodings and phase sequencing for the intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    RED_A     = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    RED_B     = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    FLASH     = 3'd6
  } phase_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic phase_e next_phase(input phase_e cur);
    phase_e nxt;
    case (cur)
      RED_A:     nxt = NS_GREEN;
      NS_GREEN:  nxt = NS_YELLOW;
      NS_YELLOW: nxt = RED_B;
      RED_B:     nxt = EW_GREEN;
      EW_GREEN:  nxt = EW_YELLOW;
      EW_YELLOW: nxt = RED_A;
      default:   nxt = RED_A;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter holding the seconds left in the current phase.
module phase_timer #(
  parameter int W       = 7,
  parameter int RST_VAL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last,
  output logic         pre_last
);

  logic [W-1:0] count_r;

  // Load wins over counting; counting stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= W'(RST_VAL);
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count    = count_r;
  assign last     = (count_r == {W{1'b0}});
  assign pre_last = (count_r == W'(1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer with pedestrian walk insertion and flashing-yellow maintenance mode.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int pGREEN_NS  = 25,
  parameter int pGREEN_EW  = 20,
  parameter int pYELLOW    = 3,
  parameter int pALL_RED   = 2,
  parameter int pPED_SHORT = 5,
  parameter int pPED_WALK  = 8,
  parameter int pMAX_VAL   = 99
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tick,
  input  logic                            ped_req,
  input  logic                            flash_mode,
  output logic [2:0]                      ns_light,
  output logic [2:0]                      ew_light,
  output logic                            ped_walk,
  output logic [$clog2(pMAX_VAL+1)-1:0]   remaining,
  output logic [2:0]                      phase
);

  localparam int W = $clog2(pMAX_VAL + 1);

  if ((pGREEN_NS < 1) || (pGREEN_NS > pMAX_VAL) || (pGREEN_EW < 1) || (pGREEN_EW > pMAX_VAL) ||
      (pYELLOW < 1) || (pYELLOW > pMAX_VAL) || (pALL_RED < 1) || (pALL_RED > pMAX_VAL) ||
      (pPED_SHORT < 1) || (pPED_SHORT > pMAX_VAL) || (pPED_WALK < 1) || (pPED_WALK > pMAX_VAL) ||
      (pPED_SHORT > pGREEN_NS) || (pPED_SHORT > pGREEN_EW)) begin : g_param_err
    $fatal(1, "traffic_light_ctrl: illegal duration parameters");
  end

  function automatic logic [W-1:0] load_for(input phase_e p);
    logic [W-1:0] v;
    case (p)
      NS_GREEN:             v = W'(pGREEN_NS - 1);
      EW_GREEN:             v = W'(pGREEN_EW - 1);
      NS_YELLOW, EW_YELLOW: v = W'(pYELLOW - 1);
      default:              v = W'(pALL_RED - 1);
    endcase
    return v;
  endfunction

  phase_e       state_r, state_n;
  logic         ped_pending_r, ped_pending_n;
  logic         blink_r, blink_n;
  logic         walk_n;
  logic         pend_eff_s;
  logic         timer_load_s;
  logic [W-1:0] timer_val_s, timer_cnt_s;
  logic         timer_last_s;
  logic         unused_pre_last_s;
  logic [2:0]   ns_n_s, ew_n_s;
  logic [W-1:0] rem_n_s;
  logic [2:0]   ns_light_r, ew_light_r;
  logic         ped_walk_r;
  logic [W-1:0] remaining_r;

  phase_timer #(.W(W), .RST_VAL(pALL_RED - 1)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .en       (tick),
    .count    (timer_cnt_s),
    .last     (timer_last_s),
    .pre_last (unused_pre_last_s)
  );

  // Next phase, timer reload, pedestrian latch and blink; a request is honoured on the edge it arrives.
  always_comb begin
    state_n       = state_r;
    ped_pending_n = ped_pending_r;
    blink_n       = blink_r;
    walk_n        = ped_walk_r;
    timer_load_s  = 1'b0;
    timer_val_s   = timer_cnt_s;
    pend_eff_s    = ped_pending_r | ped_req;
    if (flash_mode) begin
      if (state_r != FLASH) begin
        state_n       = FLASH;
        ped_pending_n = 1'b0;
        walk_n        = 1'b0;
        blink_n       = 1'b0;
      end else if (tick) begin
        blink_n = ~blink_r;
      end else begin
        blink_n = blink_r;
      end
    end else if (state_r == FLASH) begin
      state_n      = RED_A;
      timer_load_s = 1'b1;
      timer_val_s  = load_for(RED_A);
      walk_n       = 1'b0;
      blink_n      = 1'b0;
    end else if (tick && timer_last_s) begin
      state_n      = next_phase(state_r);
      timer_load_s = 1'b1;
      if (((state_n == RED_A) || (state_n == RED_B)) && pend_eff_s) begin
        timer_val_s   = W'(pPED_WALK - 1);
        walk_n        = 1'b1;
        ped_pending_n = 1'b0;
      end else begin
        timer_val_s   = load_for(state_n);
        walk_n        = 1'b0;
        ped_pending_n = pend_eff_s;
      end
    end else begin
      ped_pending_n = pend_eff_s;
      if (((state_r == NS_GREEN) || (state_r == EW_GREEN)) && pend_eff_s &&
          (timer_cnt_s > W'(pPED_SHORT - 1))) begin
        timer_load_s = 1'b1;
        timer_val_s  = W'(pPED_SHORT - 1);
      end else begin
        timer_load_s = 1'b0;
      end
    end
  end

  // Lamp and remaining-seconds values as they will stand after this edge.
  always_comb begin
    ns_n_s  = LAMP_RED;
    ew_n_s  = LAMP_RED;
    rem_n_s = timer_cnt_s + W'(1);
    case (state_n)
      NS_GREEN:  ns_n_s = LAMP_GRN;
      NS_YELLOW: ns_n_s = LAMP_YEL;
      EW_GREEN:  ew_n_s = LAMP_GRN;
      EW_YELLOW: ew_n_s = LAMP_YEL;
      FLASH: begin
        ns_n_s = blink_n ? LAMP_YEL : LAMP_OFF;
        ew_n_s = blink_n ? LAMP_YEL : LAMP_OFF;
      end
      default: begin
        ns_n_s = LAMP_RED;
        ew_n_s = LAMP_RED;
      end
    endcase
    if (state_n == FLASH) begin
      rem_n_s = {W{1'b0}};
    end else if (timer_load_s) begin
      rem_n_s = timer_val_s + W'(1);
    end else if (tick && !timer_last_s) begin
      rem_n_s = timer_cnt_s;
    end else begin
      rem_n_s = timer_cnt_s + W'(1);
    end
  end

  // Sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RED_A;
      ped_pending_r <= 1'b0;
      blink_r       <= 1'b0;
    end else begin
      state_r       <= state_n;
      ped_pending_r <= ped_pending_n;
      blink_r       <= blink_n;
    end
  end

  // Output registers; reset forces all-red so nothing else lights while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ns_light_r  <= LAMP_RED;
      ew_light_r  <= LAMP_RED;
      ped_walk_r  <= 1'b0;
      remaining_r <= W'(pALL_RED);
    end else begin
      ns_light_r  <= ns_n_s;
      ew_light_r  <= ew_n_s;
      ped_walk_r  <= walk_n;
      remaining_r <= rem_n_s;
    end
  end

  assign ns_light  = ns_light_r;
  assign ew_light  = ew_light_r;
  assign ped_walk  = ped_walk_r;
  assign remaining = remaining_r;
  assign phase     = state_r;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed scoreboard bench for traffic_light_ctrl with shortened durations.
module tb_traffic_light_ctrl;

  localparam int ALLRED = 1;
  localparam int SHORT  = 2;
  localparam int WALK   = 3;
  localparam int S_RA = 0, S_NG = 1, S_NY = 2, S_RB = 3, S_EG = 4, S_EY = 5, S_FL = 6;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic [6:0] rem;
    logic [2:0] ph;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, tick, ped_req, flash_mode;
  logic [2:0] ns_light, ew_light, phase;
  logic       ped_walk;
  logic [6:0] remaining;

  int   checks = 0;
  int   errors = 0;
  int   tc = 0;
  bit   tick_all = 1'b0;
  exp_t q[$];
  int   durs[6] = '{1, 4, 2, 1, 3, 2};
  int   m_st, m_tm;
  bit   m_pend, m_walk, m_blink;

  traffic_light_ctrl #(
    .pGREEN_NS(4), .pGREEN_EW(3), .pYELLOW(2), .pALL_RED(1), .pPED_SHORT(2), .pPED_WALK(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ped_req(ped_req), .flash_mode(flash_mode),
    .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk),
    .remaining(remaining), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] lamp(input int st, input bit blink, input bit is_ns);
    case (st)
      S_NG:    return is_ns ? 3'b001 : 3'b100;
      S_NY:    return is_ns ? 3'b010 : 3'b100;
      S_EG:    return is_ns ? 3'b100 : 3'b001;
      S_EY:    return is_ns ? 3'b100 : 3'b010;
      S_FL:    return {1'b0, blink, 1'b0};
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_reset();
    m_st = S_RA; m_tm = ALLRED - 1; m_pend = 1'b0; m_walk = 1'b0; m_blink = 1'b0;
  endtask

  task automatic model(input bit tk, input bit pd, input bit fl);
    bit p;
    p = m_pend || pd;
    if (fl) begin
      if (m_st != S_FL) begin
        m_st = S_FL; m_pend = 1'b0; m_walk = 1'b0; m_blink = 1'b0;
      end else if (tk) begin
        m_blink = !m_blink;
      end
    end else if (m_st == S_FL) begin
      m_st = S_RA; m_tm = ALLRED - 1; m_walk = 1'b0; m_blink = 1'b0;
    end else if (tk && m_tm == 0) begin
      m_st = (m_st == S_EY) ? S_RA : m_st + 1;
      if ((m_st == S_RA || m_st == S_RB) && p) begin
        m_tm = WALK - 1; m_walk = 1'b1; m_pend = 1'b0;
      end else begin
        m_tm = durs[m_st] - 1; m_walk = 1'b0; m_pend = p;
      end
    end else begin
      m_pend = p;
      if ((m_st == S_NG || m_st == S_EG) && p && m_tm > SHORT - 1) m_tm = SHORT - 1;
      else if (tk) m_tm--;
    end
  endtask

  task automatic step(input bit pd, input bit fl);
    exp_t e;
    bit   tk;
    tk = tick_all || (tc % 4 == 3);
    tc++;
    tick = tk; ped_req = pd; flash_mode = fl;
    model(tk, pd, fl);
    e.ns   = lamp(m_st, m_blink, 1'b1);
    e.ew   = lamp(m_st, m_blink, 1'b0);
    e.walk = m_walk;
    e.rem  = (m_st == S_FL) ? 7'd0 : 7'(m_tm + 1);
    e.ph   = 3'(m_st);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("ns_light", ns_light, e.ns);
    chk("ew_light", ew_light, e.ew);
    chk("ped_walk", ped_walk, e.walk);
    chk("remaining", remaining, e.rem);
    chk("phase", phase, e.ph);
    tick = 1'b0; ped_req = 1'b0;
  endtask

  task automatic run_until(input int st, input int tm, input bit need_tick, input int maxc);
    int n;
    n = 0;
    while (!(m_st == st && m_tm == tm && (!need_tick || tick_all || tc % 4 == 3)) && n < maxc) begin
      step(1'b0, flash_mode);
      n++;
    end
    checks++;
    assert (n < maxc) else begin
      errors++;
      $error("FAIL run_until_timeout observed=%0d expected<%0d", n, maxc);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; ped_req = 1'b0; flash_mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ns", ns_light, 3'b100);
    chk("rst_ew", ew_light, 3'b100);
    chk("rst_walk", ped_walk, 1'b0);
    chk("rst_rem", remaining, 7'd1);
    chk("rst_phase", phase, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: free-running sequence over several full cycles
    run_until(S_NG, 3, 1'b0, 40);
    chk("ng_entry_rem", remaining, 7'd4);
    repeat (60) step(1'b0, 1'b0);

    // 2: request at NS_GREEN remaining=4 away from a tick
    run_until(S_NG, 3, 1'b0, 80);
    while (tc % 4 == 3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("clamp_rem", remaining, 7'd2);
    run_until(S_RB, 2, 1'b0, 40);
    chk("walk_rb", ped_walk, 1'b1);
    run_until(S_EG, 2, 1'b0, 40);
    chk("walk_drop", ped_walk, 1'b0);
    chk("eg_rem", remaining, 7'd3);

    // 3a: request at remaining=1, no clamp but walk still granted
    run_until(S_NG, 0, 1'b0, 80);
    while (tc % 4 == 3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("noclamp_rem", remaining, 7'd1);
    run_until(S_RB, 2, 1'b0, 40);
    chk("walk_rb2", ped_walk, 1'b1);
    // 3b: request coincident with a tick at remaining=4
    run_until(S_NG, 3, 1'b1, 80);
    step(1'b1, 1'b0);
    chk("coinc_rem", remaining, 7'd2);

    // 4: flash from EW_YELLOW, requests ignored, then release
    run_until(S_EY, 1, 1'b0, 80);
    step(1'b0, 1'b1);
    chk("fl_ns", ns_light, 3'b000);
    chk("fl_rem", remaining, 7'd0);
    for (int i = 0; i < 12; i++) step(i % 3 == 0, 1'b1);
    step(1'b0, 1'b0);
    chk("fl_exit_phase", phase, 3'd0);
    chk("fl_exit_walk", ped_walk, 1'b0);
    run_until(S_NG, 3, 1'b0, 20);
    chk("fl_ng_rem", remaining, 7'd4);

    // 5: async reset mid EW_GREEN with a request pending
    run_until(S_EG, 2, 1'b0, 80);
    while (tc % 4 == 3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ns", ns_light, 3'b100);
    chk("arst_ew", ew_light, 3'b100);
    chk("arst_walk", ped_walk, 1'b0);
    chk("arst_rem", remaining, 7'd1);
    chk("arst_phase", phase, 3'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("arst_nowalk", ped_walk, 1'b0);
    run_until(S_NG, 3, 1'b0, 20);
    run_until(S_NY, 1, 1'b0, 40);
    run_until(S_RB, 0, 1'b0, 40);

    // 6: tick held high, one full cycle in 13 clocks
    tick_all = 1'b1;
    run_until(S_RA, 0, 1'b0, 40);
    repeat (12) step(1'b0, 1'b0);
    chk("hold_12", phase, 3'd5);
    step(1'b0, 1'b0);
    chk("hold_13", phase, 3'd0);
    repeat (20) step(1'b0, 1'b0);
    tick_all = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Two-road (NS/EW) intersection sequencer that drives the lamp outputs and schedules phase durations in whole seconds.
- Owns one loadable down-counting phase timer, advanced by an external 1 Hz `tick` enable.
- Adds a pedestrian request that shortens the running green and inserts a walk interval.
- Adds a flashing-yellow maintenance mode. Sits between the seconds prescaler and the lamp/display drivers.

Parameters:
- pGREEN_NS, 25, NS green duration in ticks.
- pGREEN_EW, 20, EW green duration in ticks.
- pYELLOW, 3, yellow duration in ticks (both roads).
- pALL_RED, 2, all-red clearance duration in ticks.
- pPED_SHORT, 5, maximum remaining green after a pedestrian request.
- pPED_WALK, 8, all-red duration when a walk is granted.
- pMAX_VAL, 99, largest legal duration; sets the counter width.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous, active-low reset.
- tick, in, 1, one-clk pulse per second; timer advances only when high.
- ped_req, in, 1, pedestrian button, level or pulse; latched internally.
- flash_mode, in, 1, maintenance mode while high.
- ns_light, out, 3, {red, yellow, green} for the NS road.
- ew_light, out, 3, {red, yellow, green} for the EW road.
- ped_walk, out, 1, walk lamp.
- remaining, out, W = $clog2(pMAX_VAL+1), seconds left in the current phase (N..1).
- phase, out, 3, current state encoding (debug).

Behaviour:
- Elaboration check: every duration must be in 1..pMAX_VAL, and pPED_SHORT must be ≤ both green durations. Violations are a fatal error.
- Registered outputs; every output is a decode of state, timer and blink bits.
- States and lamps:
  - RED_A: ns=100, ew=100.
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - RED_B: ns=100, ew=100.
  - EW_GREEN: ns=100, ew=001.
  - EW_YELLOW: ns=100, ew=010.
  - FLASH: ns=ew={0, blink, 0}.
- Normal order: RED_A -> NS_GREEN -> NS_YELLOW -> RED_B -> EW_GREEN -> EW_YELLOW -> RED_A.
- Timer on phase entry: loaded with (duration - 1).
  - Each tick with timer > 0 decrements it.
  - A tick with timer == 0 advances the state and loads the next duration in the same clk edge.
  - Each phase therefore lasts exactly duration ticks.
- remaining = timer + 1 in all non-FLASH states; 0 in FLASH.
- Reset values: state RED_A, timer = pALL_RED - 1, ns_light = ew_light = 100, ped_walk = 0, remaining = pALL_RED, ped_pending = 0, blink = 0, phase = RED_A.
- Reset mid-operation returns to the reset values immediately (async). No lamp other than red is driven while reset is asserted.
- Pedestrian request:
  - ped_req high sets ped_pending on the next edge, except in FLASH, where it is ignored.
  - In NS_GREEN or EW_GREEN, when ped_pending = 1 and timer > pPED_SHORT - 1, the timer is loaded with pPED_SHORT - 1 on that edge.
  - This clamp takes priority over a coincident tick decrement. It applies once; it is a no-op if the timer is already ≤ pPED_SHORT - 1.
- Walk grant:
  - On entry to RED_A or RED_B with ped_pending = 1: load pPED_WALK - 1 instead of pALL_RED - 1, set ped_walk = 1 for the whole phase, clear ped_pending.
  - ped_walk drops on leaving the red phase.
- A request arriving during a red or yellow phase stays pending until the next green, which is then shortened.
- A request arriving during a walk phase stays pending; it shortens the following green and grants another walk.
- Flash mode:
  - flash_mode = 1 forces FLASH on the next edge from any state, including mid-phase.
  - Entering FLASH clears ped_pending, ped_walk and blink.
  - In FLASH, blink toggles on each tick.
  - flash_mode = 0 while in FLASH -> RED_A with pALL_RED (no walk), then the normal sequence.
- tick held high for multiple clks counts one second per clk; no edge detection is done here.

Decomposition:
- Package traffic_pkg:
  - phase_e enum (RED_A, NS_GREEN, NS_YELLOW, RED_B, EW_GREEN, EW_YELLOW, FLASH).
  - Lamp constants LAMP_RED = 3'b100, LAMP_YEL = 3'b010, LAMP_GRN = 3'b001, LAMP_OFF = 3'b000.
  - Function next_phase().
- Sub-module phase_timer.
  - Inputs: load, load_val, en (tick).
  - Outputs: count, last (count == 0), pre_last (count == 1).
  - Async active-low reset to pALL_RED - 1.
- The FSM in traffic_light_ctrl drives load/load_val and consumes last.

Test Plan:
All scenarios use pGREEN_NS=4, pGREEN_EW=3, pYELLOW=2, pALL_RED=1, pPED_SHORT=2, pPED_WALK=3, tick every 4 clks.
1. Reset release with no ped_req.
   - Phases last 1/4/2/1/3/2 ticks, in order.
   - remaining counts 4,3,2,1 in NS_GREEN; cycle repeats after 13 ticks.
2. Pulse ped_req at NS_GREEN with remaining = 4.
   - Next edge: remaining = 2; NS_GREEN ends 2 ticks later; yellow lasts 2 ticks.
   - RED_B lasts 3 ticks with ped_walk = 1; then EW_GREEN with remaining = 3 and ped_walk = 0.
3. ped_req at NS_GREEN with remaining = 1, and separately ped_req coincident with a tick at remaining = 4.
   - remaining = 1 case: no clamp, walk still granted in RED_B.
   - Coincident case: the clamp wins and remaining = 2.
4. flash_mode = 1 during EW_YELLOW.
   - Next edge: ns = ew = 000 and remaining = 0; yellow toggles on each tick; ped_req is ignored.
   - Release: RED_A for 1 tick with no walk, then NS_GREEN with remaining = 4.
5. Assert rst_n = 0 mid EW_GREEN, with a pending request.
   - Outputs go to reset values without waiting for clk; ped_pending is cleared.
   - After release, no walk in the first RED_A.
6. tick held high continuously.
   - Full cycle completes in 13 clks; phase durations are unchanged in ticks.
